decoder_scan_ctrl: RTL



---
 rtl/decoder_scan_pkg.sv | 14 +
 rtl/scan_next_ch.sv | 32 +++
 rtl/decoder_scan_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder select-code scanner.
// Imported by the scanner top and its channel-search helper.
package decoder_scan_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_DWELL
   } state_e;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;
   localparam int   N_CH        = 4;

endpackage

// File: rtl/scan_next_ch.sv
// Circular next-enabled-channel search: first set mask bit strictly after cur_i, wrapping 3->0.
// With cur_i=3 it yields the lowest enabled channel, which is how a fresh pass picks its start.
module scan_next_ch
   import decoder_scan_pkg::*;
(
   input  logic [1:0] cur_i,
   input  logic [3:0] mask_i,
   output logic [1:0] nxt_o,
   output logic       wrap_o,
   output logic       none_o
);

   logic [1:0] idx;
   logic       found;

   // Offset N_CH lands back on cur_i, covering the single-enabled-channel case.
   always_comb begin
      nxt_o = cur_i;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = cur_i + 2'(k);
         if (!found && mask_i[idx]) begin
            nxt_o = idx;
            found = 1'b1;
         end
      end
      none_o = (mask_i == 4'b0000);
      wrap_o = found && (nxt_o <= cur_i);
   end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Generates the 2-bit select code for the downstream 2-to-4 decoder, stepping through
// enabled channels with a programmable dwell and flagging channel entry and end of pass.
module decoder_scan_ctrl
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [3:0]         mask_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic [1:0]         sel_o,
   output logic               sel_valid_o,
   output logic               strobe_o,
   output logic               pass_done_o,
   output logic               busy_o
);

   state_e               state_q, state_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [1:0]           sel_q, sel_d;
   logic                 selValid_q, selValid_d;
   logic                 strobe_q, strobe_d;
   logic                 passDone_q, passDone_d;
   logic                 busy_q, busy_d;

   logic [1:0]           searchCur, searchNxt;
   logic                 searchWrap, searchNone;
   logic [1:0]           lookNxt;
   logic                 lookWrap, lookNone;

   assign searchCur = (state_q == ST_IDLE) ? 2'(N_CH - 1) : sel_q;

   scan_next_ch uSearch (
      .cur_i  (searchCur),
      .mask_i (mask_i),
      .nxt_o  (searchNxt),
      .wrap_o (searchWrap),
      .none_o (searchNone)
   );

   // Registered pass_done must be decided one edge early, so look ahead from the channel being entered.
   scan_next_ch uLook (
      .cur_i  (sel_d),
      .mask_i (mask_i),
      .nxt_o  (lookNxt),
      .wrap_o (lookWrap),
      .none_o (lookNone)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      selValid_d = selValid_q;
      busy_d     = busy_q;
      strobe_d   = 1'b0;
      if (!en_i) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         sel_d      = '0;
         selValid_d = 1'b0;
         busy_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i && !searchNone) begin
                  state_d    = ST_DWELL;
                  sel_d      = searchNxt;
                  cnt_d      = dwell_i;
                  selValid_d = 1'b1;
                  busy_d     = 1'b1;
                  strobe_d   = 1'b1;
               end
            end
            ST_DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else if (searchNone || (searchWrap && mode_i == MODE_SINGLE)) begin
                  state_d    = ST_IDLE;
                  cnt_d      = '0;
                  sel_d      = '0;
                  selValid_d = 1'b0;
                  busy_d     = 1'b0;
               end else begin
                  sel_d    = searchNxt;
                  cnt_d    = dwell_i;
                  strobe_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign passDone_d = (state_d == ST_DWELL) && (cnt_d == '0) && lookWrap && !lookNone;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         selValid_q <= 1'b0;
         strobe_q   <= 1'b0;
         passDone_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         selValid_q <= selValid_d;
         strobe_q   <= strobe_d;
         passDone_q <= passDone_d;
         busy_q     <= busy_d;
      end
   end

   assign sel_o       = sel_q;
   assign sel_valid_o = selValid_q;
   assign strobe_o    = strobe_q;
   assign pass_done_o = passDone_q;
   assign busy_o      = busy_q;

endmodule
